// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, drives the baud generator, deframes
// start/data/parity/stop into a one-entry holding register with error flags.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 baud_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state, state_nxt;
    logic                 rx_m, rx_s, rx_s_q;
    logic [DATA_BITS-1:0] shift;
    logic [3:0]           bit_cnt;
    logic                 par_bad;
    logic                 tick, start_edge, last_bit, frame_done, load;

    assign tick       = baud_tick & baud_en;
    assign start_edge = rx_s_q & ~rx_s;
    assign last_bit   = (bit_cnt == 4'(DATA_BITS - 1));
    assign frame_done = (state == STOP) && tick;
    // A completing frame may land if the slot is empty or being drained this cycle
    assign load       = frame_done && (!rx_valid || rx_ready);

    assign baud_en = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        baud_clr  = 1'b0;
        case (state)
            IDLE:      if (start_edge) begin
                           baud_clr  = 1'b1;
                           state_nxt = START;
                       end
            START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (tick && last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    if (tick) state_nxt = STOP;
            STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_s_q      <= 1'b1;
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            par_bad     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_q <= rx_s;
            state  <= state_nxt;

            if (state == START && tick) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end
            // LSB arrives first, so new bits enter at the top and walk down
            if (state == DATA && tick) begin
                shift   <= {rx_s, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == PARITY && tick)
                par_bad <= rx_s ^ (^shift) ^ 1'(PARITY_ODD);

            if (load) begin
                rx_data    <= shift;
                rx_valid   <= 1'b1;
                frame_err  <= ~rx_s;
                parity_err <= (PARITY_EN != 0) && par_bad;
            end else begin
                if (frame_done) overrun_err <= 1'b1;
                if (rx_valid && rx_ready) begin
                    rx_valid   <= 1'b0;
                    frame_err  <= 1'b0;
                    parity_err <= 1'b0;
                end
            end
        end
    end

endmodule
